// File: rtl/aurora_bist_pkg.sv
// Shared PRBS-31 definitions for the Aurora BIST generator and checker.
// Polynomial x^31+x^28+1, serial MSB-first, 64 bits per word.
package aurora_bist_pkg;

   localparam int PRBS_LEN = 31;
   localparam int PRBS_TAP = 28;
   localparam int WORD_W   = 64;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      LOCKED
   } bist_state_t;

   typedef struct packed {
      logic [WORD_W-1:0]   word;
      logic [PRBS_LEN-1:0] state;
   } prbs_step_t;

   // state[30] is the oldest bit; the new bit is state[30] ^ state[27]
   function automatic prbs_step_t prbs31_next64(
      input logic [PRBS_LEN-1:0] state
   );
      prbs_step_t r;
      logic [PRBS_LEN-1:0] s;
      logic b;
      s = state;
      r.word = '0;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         b = s[PRBS_LEN-1] ^ s[PRBS_TAP-1];
         r.word[i] = b;
         s = {s[PRBS_LEN-2:0], b};
      end
      r.state = s;
      return r;
   endfunction

endpackage

// File: rtl/aurora_prbs31_step.sv
// Combinational 64-bit advance of the PRBS-31 LFSR.
// Produces the next word and the LFSR state after that word.
module aurora_prbs31_step
   import aurora_bist_pkg::*;
(
   input  logic [PRBS_LEN-1:0] state,
   output logic [WORD_W-1:0]   word,
   output logic [PRBS_LEN-1:0] next_state
);

   prbs_step_t step;

   always_comb begin
      step = prbs31_next64(state);
   end

   assign word       = step.word;
   assign next_state = step.state;

endmodule

// File: rtl/aurora_bist_checker.sv
// PRBS-31 BIST checker on the 64-bit Aurora RX stream.
// Three stages: capture, compare/popcount, counters/state.
module aurora_bist_checker
   import aurora_bist_pkg::*;
#(
   parameter int LOCK_COUNT   = 16,
   parameter int UNLOCK_COUNT = 4,
   parameter int CNT_W        = 48
) (
   input  logic             phy_clk,
   input  logic             phy_rst_n,
   input  logic             clear,
   input  logic             checker_en,
   input  logic             channel_up,
   input  logic [63:0]      s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             checker_locked,
   output logic [CNT_W-1:0] checker_samps,
   output logic [CNT_W-1:0] checker_errors
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] sum;
      logic [3:0] cnt;
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = '0;
         for (int j = 0; j < 8; j++) cnt = cnt + {3'b0, v[8*i+j]};
         sum = sum + {3'b0, cnt};
      end
      return sum;
   endfunction

   bist_state_t state_q, state_d;
   logic        en_q;
   logic        flush;
   logic        lock_now;

   logic        s1_valid;
   logic [63:0] s1_data;

   logic        have_prev;
   logic [30:0] prev_word;
   logic [30:0] lfsr;
   logic [63:0] pred_word, lfsr_word, exp_word;
   logic [30:0] pred_state, lfsr_next;
   logic [6:0]  pop;

   logic        s2_valid;
   logic        s2_cmp;
   logic [6:0]  s2_pop;

   logic [7:0]       match_run, match_run_d;
   logic [7:0]       err_run, err_run_d;
   logic [CNT_W-1:0] samps_d, errors_d;
   logic [CNT_W:0]   err_sum;

   // stage 1
   always_ff @(posedge phy_clk or negedge phy_rst_n) begin
      if (!phy_rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= s_axis_tvalid & ~flush;
         if (s_axis_tvalid) s1_data <= s_axis_tdata;
      end
   end

   aurora_prbs31_step u_pred (
      .state      (prev_word),
      .word       (pred_word),
      .next_state (pred_state)
   );

   aurora_prbs31_step u_lfsr (
      .state      (lfsr),
      .word       (lfsr_word),
      .next_state (lfsr_next)
   );

   always_comb begin
      exp_word = (state_q == LOCKED) ? lfsr_word : pred_word;
      pop      = popcount64(s1_data ^ exp_word);
   end

   // stage 2; the LFSR is seeded from the prediction chain at lock
   always_ff @(posedge phy_clk or negedge phy_rst_n) begin
      if (!phy_rst_n) begin
         s2_valid  <= 1'b0;
         s2_cmp    <= 1'b0;
         s2_pop    <= '0;
         have_prev <= 1'b0;
         prev_word <= '0;
         lfsr      <= '0;
      end else begin
         s2_valid <= s1_valid & ~flush;
         if (s1_valid) begin
            s2_pop <= pop;
            s2_cmp <= have_prev;
         end
         if (flush) begin
            have_prev <= 1'b0;
         end else if (s1_valid) begin
            have_prev <= 1'b1;
            prev_word <= s1_data[30:0];
         end
         if (s1_valid && !flush) begin
            if (state_q == LOCKED) lfsr <= lfsr_next;
            else if (lock_now)     lfsr <= pred_state;
         end else if (lock_now) begin
            lfsr <= prev_word;
         end
      end
   end

   // stage 3
   always_comb begin
      state_d     = state_q;
      match_run_d = match_run;
      err_run_d   = err_run;
      samps_d     = checker_samps;
      errors_d    = checker_errors;
      flush       = 1'b0;
      lock_now    = 1'b0;
      err_sum     = {1'b0, checker_errors} + {{(CNT_W-6){1'b0}}, s2_pop};
      if (clear || (checker_en && !en_q)) begin
         samps_d  = '0;
         errors_d = '0;
      end
      if (!checker_en) begin
         state_d     = IDLE;
         match_run_d = '0;
         err_run_d   = '0;
         flush       = 1'b1;
      end else if (clear || !channel_up || state_q == IDLE) begin
         state_d     = SEARCH;
         match_run_d = '0;
         err_run_d   = '0;
         flush       = 1'b1;
      end else if (s2_valid) begin
         unique case (state_q)
            SEARCH: begin
               if (s2_cmp) begin
                  if (s2_pop != '0) begin
                     match_run_d = '0;
                  end else if (int'(match_run) + 1 >= LOCK_COUNT) begin
                     state_d     = LOCKED;
                     lock_now    = 1'b1;
                     match_run_d = '0;
                  end else begin
                     match_run_d = match_run + 8'd1;
                  end
               end
            end
            LOCKED: begin
               if (checker_samps != CNT_MAX) samps_d = checker_samps + CNT_ONE;
               errors_d = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
               if (s2_pop == '0) begin
                  err_run_d = '0;
               end else if (int'(err_run) + 1 >= UNLOCK_COUNT) begin
                  state_d   = SEARCH;
                  err_run_d = '0;
                  flush     = 1'b1;
               end else begin
                  err_run_d = err_run + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge phy_clk or negedge phy_rst_n) begin
      if (!phy_rst_n) begin
         state_q        <= IDLE;
         en_q           <= 1'b0;
         match_run      <= '0;
         err_run        <= '0;
         checker_locked <= 1'b0;
         checker_samps  <= '0;
         checker_errors <= '0;
      end else begin
         state_q        <= state_d;
         en_q           <= checker_en;
         match_run      <= match_run_d;
         err_run        <= err_run_d;
         checker_locked <= (state_d == LOCKED);
         checker_samps  <= samps_d;
         checker_errors <= errors_d;
      end
   end

endmodule

// File: tb/tb_aurora_bist_checker.sv
// Directed bench for aurora_bist_checker: lock, errors, unlock,
// gaps, clear/enable/channel control, saturation and async reset.
module tb_aurora_bist_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        en;
   logic        chan_up;
   logic        tvalid;
   logic [63:0] tdata;
   logic        locked, locked8;
   logic [47:0] samps, errors;
   logic [7:0]  samps8, errors8;
   logic [30:0] gstate;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   aurora_bist_checker #(
      .LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_W(48)
   ) dut (
      .phy_clk(clk), .phy_rst_n(rst_n), .clear(clear),
      .checker_en(en), .channel_up(chan_up),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .checker_locked(locked), .checker_samps(samps),
      .checker_errors(errors)
   );

   aurora_bist_checker #(
      .LOCK_COUNT(16), .UNLOCK_COUNT(255), .CNT_W(8)
   ) dut8 (
      .phy_clk(clk), .phy_rst_n(rst_n), .clear(clear),
      .checker_en(en), .channel_up(chan_up),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
      .checker_locked(locked8), .checker_samps(samps8),
      .checker_errors(errors8)
   );

   // bit-serial reference: b[n] = b[n-31] ^ b[n-28], oldest bit highest
   task automatic next_word(output logic [63:0] w);
      logic [94:0] h;
      h = {gstate, 64'd0};
      for (int n = 63; n >= 0; n--) h[n] = h[n+31] ^ h[n+28];
      w = h[63:0];
      gstate = h[30:0];
   endtask

   task automatic send(input logic [63:0] d, input logic v);
      tdata  = d;
      tvalid = v;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      idle(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; en = 1'b0; chan_up = 1'b1;
      tvalid = 1'b0; tdata = '0; gstate = 31'h2545_F491;
      idle(3);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
      checks++; if (samps !== 48'd0) begin failures++; $display("FAIL reset_samps got=%0d exp=0", samps); end
      checks++; if (errors !== 48'd0) begin failures++; $display("FAIL reset_errors got=%0d exp=0", errors); end
      rst_n = 1'b1;
      idle(2);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL idle_locked got=%0b exp=0", locked); end
      en = 1'b1;
      idle(3);
   endtask

   task automatic test_lock_clean();
      logic [63:0] w;
      for (int i = 0; i < 200; i++) begin
         if (i == 18) begin
            checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0b exp=0", locked); end
         end
         if (i == 19) begin
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_rise got=%0b exp=1", locked); end
         end
         next_word(w);
         send(w, 1'b1);
      end
      idle(3);
      checks++; if (samps !== 48'd183) begin failures++; $display("FAIL clean_samps got=%0d exp=183", samps); end
      checks++; if (errors !== 48'd0) begin failures++; $display("FAIL clean_errors got=%0d exp=0", errors); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clean_locked got=%0b exp=1", locked); end
   endtask

   task automatic test_bit_errors();
      logic [63:0] w;
      pulse_clear();
      for (int i = 0; i < 200; i++) begin
         next_word(w);
         if (i == 100) w = w ^ 64'h21;
         send(w, 1'b1);
      end
      idle(3);
      checks++; if (samps !== 48'd183) begin failures++; $display("FAIL biterr_samps got=%0d exp=183", samps); end
      checks++; if (errors !== 48'd2) begin failures++; $display("FAIL biterr_errors got=%0d exp=2", errors); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL biterr_locked got=%0b exp=1", locked); end
   endtask

   task automatic test_unlock();
      logic [63:0] w;
      int pc, n, at;
      logic found;
      pc = 0;
      for (int k = 0; k < 4; k++) begin
         next_word(w);
         pc += $countones(w);
         send(64'd0, 1'b1);
      end
      next_word(w);
      send(w, 1'b1);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL unlock_hold got=%0b exp=1", locked); end
      next_word(w);
      send(w, 1'b1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL unlock_fall got=%0b exp=0", locked); end
      checks++; if (samps !== 48'd187) begin failures++; $display("FAIL unlock_samps got=%0d exp=187", samps); end
      checks++;
      if (errors !== 48'(2 + pc)) begin
         failures++; $display("FAIL unlock_errors got=%0d exp=%0d", errors, 2 + pc);
      end
      found = 1'b0; at = 0; n = 2;
      for (int i = 0; i < 40; i++) begin
         if (!found) begin
            next_word(w);
            send(w, 1'b1);
            n++;
            if (locked === 1'b1) begin found = 1'b1; at = n; end
         end
      end
      checks++;
      if (!found || at < 18 || at > 24) begin
         failures++; $display("FAIL relock found=%0b beats=%0d exp=18..24", found, at);
      end
   endtask

   task automatic test_gaps();
      logic [63:0] w;
      pulse_clear();
      for (int i = 0; i < 100; i++) begin
         next_word(w);
         send(w, 1'b1);
         idle(3);
      end
      idle(1);
      checks++; if (samps !== 48'd83) begin failures++; $display("FAIL gap_samps got=%0d exp=83", samps); end
      checks++; if (errors !== 48'd0) begin failures++; $display("FAIL gap_errors got=%0d exp=0", errors); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_locked got=%0b exp=1", locked); end
   endtask

   task automatic test_clear();
      logic [63:0] w;
      for (int i = 0; i < 5; i++) begin
         next_word(w);
         send(w, 1'b1);
      end
      idle(1);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      checks++; if (samps !== 48'd0) begin failures++; $display("FAIL clear_samps got=%0d exp=0", samps); end
      checks++; if (errors !== 48'd0) begin failures++; $display("FAIL clear_errors got=%0d exp=0", errors); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL clear_locked got=%0b exp=0", locked); end
      for (int i = 0; i < 40; i++) begin
         next_word(w);
         send(w, 1'b1);
      end
      idle(3);
      checks++; if (samps !== 48'd23) begin failures++; $display("FAIL clear_relock_samps got=%0d exp=23", samps); end
   endtask

   task automatic test_enable_toggle();
      en = 1'b0;
      idle(1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL endis_locked got=%0b exp=0", locked); end
      checks++; if (samps !== 48'd23) begin failures++; $display("FAIL endis_hold got=%0d exp=23", samps); end
      en = 1'b1;
      idle(1);
      checks++; if (samps !== 48'd0) begin failures++; $display("FAIL enrise_samps got=%0d exp=0", samps); end
      checks++; if (errors !== 48'd0) begin failures++; $display("FAIL enrise_errors got=%0d exp=0", errors); end
   endtask

   task automatic test_channel_down();
      logic [63:0] w;
      for (int i = 0; i < 30; i++) begin
         next_word(w);
         send(w, 1'b1);
      end
      idle(3);
      checks++; if (samps !== 48'd13) begin failures++; $display("FAIL chan_pre_samps got=%0d exp=13", samps); end
      chan_up = 1'b0;
      next_word(w);
      send(w, 1'b1);
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL chan_locked got=%0b exp=0", locked); end
      checks++; if (samps !== 48'd13) begin failures++; $display("FAIL chan_samps got=%0d exp=13", samps); end
      for (int i = 0; i < 3; i++) begin
         next_word(w);
         send(w, 1'b1);
      end
      idle(2);
      checks++; if (samps !== 48'd13) begin failures++; $display("FAIL chan_ignore got=%0d exp=13", samps); end
      chan_up = 1'b1;
      idle(2);
   endtask

   task automatic test_saturation();
      logic [63:0] w;
      pulse_clear();
      for (int i = 0; i < 20; i++) begin
         next_word(w);
         send(w, 1'b1);
      end
      idle(3);
      checks++; if (locked8 !== 1'b1) begin failures++; $display("FAIL sat_lock got=%0b exp=1", locked8); end
      checks++; if (samps8 !== 8'd3) begin failures++; $display("FAIL sat_pre_samps got=%0d exp=3", samps8); end
      for (int i = 0; i < 31; i++) begin
         next_word(w);
         send(w ^ 64'hFF00_0000_0000_0000, 1'b1);
      end
      idle(3);
      checks++; if (errors8 !== 8'd248) begin failures++; $display("FAIL sat_248 got=%0d exp=248", errors8); end
      for (int i = 0; i < 2; i++) begin
         next_word(w);
         send(w ^ 64'hFF00_0000_0000_0000, 1'b1);
      end
      idle(3);
      checks++; if (errors8 !== 8'd255) begin failures++; $display("FAIL sat_clamp got=%0d exp=255", errors8); end
      checks++; if (samps8 !== 8'd36) begin failures++; $display("FAIL sat_samps got=%0d exp=36", samps8); end
      checks++; if (locked8 !== 1'b1) begin failures++; $display("FAIL sat_locked got=%0b exp=1", locked8); end
      checks++; if (errors !== 48'd32) begin failures++; $display("FAIL wide_errors got=%0d exp=32", errors); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL wide_unlock got=%0b exp=0", locked); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (errors8 !== 8'd0) begin failures++; $display("FAIL arst_errors8 got=%0d exp=0", errors8); end
      checks++; if (samps8 !== 8'd0) begin failures++; $display("FAIL arst_samps8 got=%0d exp=0", samps8); end
      checks++; if (locked8 !== 1'b0) begin failures++; $display("FAIL arst_locked8 got=%0b exp=0", locked8); end
      checks++; if (errors !== 48'd0) begin failures++; $display("FAIL arst_errors got=%0d exp=0", errors); end
      checks++; if (samps !== 48'd0) begin failures++; $display("FAIL arst_samps got=%0d exp=0", samps); end
      idle(2);
      rst_n = 1'b1;
      idle(2);
   endtask

   initial begin
      test_reset();
      test_lock_clean();
      test_bit_errors();
      test_unlock();
      test_gaps();
      test_clear();
      test_enable_toggle();
      test_channel_down();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
